muldiv_iter: RTL

- Parametrised, multi-cycle RV32M-style multiply/divide unit. It is the successor to the single-cycle combinational multiply path in the ALU.
- Supports all eight M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at any WIDTH.
- Uses a radix-2 iterative datapath, so no WIDTH×WIDTH combinational multiplier is needed.
- Sits beside the ALU in execute. Uses a valid/ready handshake on both sides, so the pipeline stalls on in_ready / out_valid.

---
 rtl/muldiv_iter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 RV32M multiply/divide unit with valid/ready handshakes.
// Shift-add multiply and restoring divide on magnitudes; signs are applied in a final fix-up cycle.
`default_nettype none

module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               neg_r;

  logic               is_div;
  logic               a_signed;
  logic               b_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   special_val;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_val;

  assign in_ready = (state == IDLE);

  // Operand classification, valid while a_q/b_q still hold the raw operands (PREP)
  assign is_div   = op_q[2];
  assign a_signed = (op_q == 3'd0) || (op_q == 3'd1) || (op_q == 3'd2) ||
                    (op_q == 3'd4) || (op_q == 3'd6);
  assign b_signed = (op_q == 3'd0) || (op_q == 3'd1) ||
                    (op_q == 3'd4) || (op_q == 3'd6);
  assign a_neg    = a_signed && a_q[WIDTH-1];
  assign b_neg    = b_signed && b_q[WIDTH-1];
  assign a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
  assign b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
  assign div_zero = is_div && (b_q == '0);
  assign div_ovf  = is_div && !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);

  always_comb begin
    special_val = '0;
    if (div_zero) special_val = op_q[1] ? a_q : '1;
    else if (div_ovf) special_val = op_q[1] ? '0 : a_q;
  end

  // Multiply step: multiplier sits in the low half and shifts out LSB-first
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Restoring divide step: partial remainder high, dividend/quotient low
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, b_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

  assign prod = neg_q ? (~acc + 1'b1) : acc;
  assign quo  = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_val = '0;
    if (!is_div) fix_val = (op_q == 3'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else if (op_q[1]) fix_val = neg_r ? (~rem + 1'b1) : rem;
    else fix_val = neg_q ? (~quo + 1'b1) : quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result    <= '0;
      zero_flag <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            a_q   <= operand_a;
            b_q   <= operand_b;
            state <= PREP;
          end
        end
        PREP: begin
          if (div_zero || div_ovf) begin
            result    <= special_val;
            zero_flag <= (special_val == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc   <= {{WIDTH{1'b0}}, a_mag};
            b_q   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= CNT_W'(WIDTH);
            state <= CALC;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          result    <= fix_val;
          zero_flag <= (fix_val == '0);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
